// File: rtl/conv_out_collector_if.sv
// conv_out_collector_if
//   Pixel input stream and FIFO pop port of the convolution output collector.
//   pix_valid / pix_in : incoming convolved pixel, valid for one cycle, no back-pressure
//   out_valid / out_data / out_ready : show-ahead pop port
//   Handshake: a word transfers on a rising edge where out_valid && out_ready are both 1.
//   out_valid does not depend on out_ready. out_data stays stable while out_valid is 1
//   and no transfer has occurred. out_ready may be asserted while out_valid is 0; this
//   has no effect.
//   modport master : collector side (drives out_valid/out_data)
//   modport slave  : upstream/readout side (drives pix_valid/pix_in/out_ready)
interface conv_out_collector_if #(
    parameter int BITS = 9
) ();
    logic            pix_valid;
    logic [BITS-1:0] pix_in;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            out_ready;

    modport master (
        input  pix_valid,
        input  pix_in,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport slave (
        output pix_valid,
        output pix_in,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/conv_out_collector.sv
// conv_out_collector
//   Follows convolve. Tracks the output column and row. Drops window positions that wrap
//   across two image rows. Queues the valid pixels in a show-ahead FIFO for the readout
//   logic. Pulses row_done and frame_done.
// Ports
//   clk, reset_n  : clock; asynchronous active-low reset
//   frame_start   : clears the position and enters RUN (the FIFO contents are kept)
//   bus           : pixel input and FIFO pop port (conv_out_collector_if.master)
//   fifo_count    : number of occupied FIFO entries
//   overflow      : sticky; a kept pixel was dropped because the FIFO was full
//   overflow_clr  : clears overflow (a set in the same cycle takes priority)
//   row_done      : 1-cycle pulse after the last column of a row
//   frame_done    : 1-cycle pulse after the last pixel of the last valid row
//   state_dbg     : FSM state (0 IDLE, 1 RUN, 2 DONE)
module conv_out_collector #(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_LENGTH  = 128,
    parameter int IMG_HEIGHT  = 128,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            frame_start,
    conv_out_collector_if.master            bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    input  logic                            overflow_clr,
    output logic                            row_done,
    output logic                            frame_done,
    output logic [1:0]                      state_dbg
);
    localparam int COL_W = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [COL_W-1:0] KEEP_MAX = COL_W'(IMG_LENGTH - KERNEL_SIZE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_LENGTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - KERNEL_SIZE);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    logic [1:0]       state, state_nxt;
    logic [COL_W-1:0] col, col_nxt, col_eff;
    logic [ROW_W-1:0] row, row_nxt, row_eff;
    logic             take, keep, wrap, frame_end;

    logic [BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             pop, push, full, ovf_set;

    // A frame_start that arrives together with pix_valid makes that pixel col 0 / row 0
    // of the new frame. For this reason the position is taken from the cleared values
    // in that cycle.
    always_comb begin
        col_eff   = frame_start ? '0 : col;
        row_eff   = frame_start ? '0 : row;
        take      = bus.pix_valid & (frame_start | (state == ST_RUN));
        keep      = take & (col_eff <= KEEP_MAX);
        wrap      = take & (col_eff == COL_LAST);
        frame_end = wrap & (row_eff == ROW_LAST);

        state_nxt = frame_start ? ST_RUN : state;
        col_nxt   = col_eff;
        row_nxt   = row_eff;
        if (take) begin
            if (wrap) begin
                col_nxt = '0;
                row_nxt = row_eff + 1'b1;
            end else begin
                col_nxt = col_eff + 1'b1;
            end
        end
        if (frame_end) state_nxt = ST_DONE;
    end

    // If the FIFO is full, a push is still accepted when the head is popped in the same
    // cycle.
    always_comb begin
        full    = (count == FULL_CNT);
        pop     = bus.out_ready & (count != '0);
        push    = keep & (~full | pop);
        ovf_set = keep & full & ~pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            row_done   <= wrap;
            frame_done <= frame_end;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (ovf_set)           overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    // The storage has no reset. Entries are only visible through count, so any stale
    // contents are masked.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.pix_in;
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign fifo_count    = count;
    assign state_dbg     = state;
endmodule
